tdm_demux4: RTL and testbench

- Four-channel time-division demultiplexer.
- Accepts a serial stream of samples, one per valid cycle, with a start-of-frame marker on slot 0.
- Steers each sample to one of four registered channel outputs y0..y3.
- Sits at the receive end of a 4-slot TDM link. Raises strobes per channel and per frame, and detects loss of frame sync.

---
 rtl/tdm_demux4.sv | 97 +++++++++
 tb/tb_tdm_demux4.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM receive demultiplexer with frame-sync tracking
// Ports: clk/rst_n (async active-low), en (clears frame state when low),
//        d_in/d_valid/sof (serial samples, sof marks slot 0),
//        y0..y3 (channel registers), s (last written slot), ch_valid (one-hot write strobe),
//        frame_done (slot 3 written), sync_err (framing violation), err_cnt (saturating error count)
module tdm_demux4 #(
    parameter int WIDTH = 1,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [1:0]       s,
    output logic [3:0]       ch_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic [ERRW-1:0]  err_cnt
);
    typedef enum logic {HUNT, RUN} state_t;
    state_t           state, state_n;
    logic [1:0]       slot, slot_n, s_n, wsel;
    logic [WIDTH-1:0] y_q [4];
    logic [WIDTH-1:0] y_n [4];
    logic [3:0]       chv_n;
    logic             fd_n, se_n, wr;
    assign y0 = y_q[0];
    assign y1 = y_q[1];
    assign y2 = y_q[2];
    assign y3 = y_q[3];
    always_comb begin
        state_n = state;
        slot_n  = slot;
        y_n     = y_q;
        s_n     = s;
        chv_n   = '0;
        fd_n    = 1'b0;
        se_n    = 1'b0;
        wr      = 1'b0;
        wsel    = '0;
        if (!en) begin
            state_n = HUNT;
            slot_n  = '0;
            y_n     = '{default: '0};
            s_n     = '0;
        end else if (d_valid) begin
            if (state == HUNT) begin
                wr      = sof;
                state_n = sof ? RUN : HUNT;
            end else if (sof) begin
                // an early sof realigns the frame: the sample becomes slot 0
                wr   = 1'b1;
                se_n = slot != 2'd0;
            end else if (slot == 2'd0) begin
                se_n    = 1'b1;
                state_n = HUNT;
            end else begin
                wr   = 1'b1;
                wsel = slot;
            end
            if (wr) begin
                y_n[wsel] = d_in;
                s_n       = wsel;
                chv_n     = 4'b0001 << wsel;
                fd_n      = wsel == 2'd3;
                slot_n    = wsel + 2'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= '0;
            y_q        <= '{default: '0};
            s          <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            slot       <= slot_n;
            y_q        <= y_n;
            s          <= s_n;
            ch_valid   <= chv_n;
            frame_done <= fd_n;
            sync_err   <= se_n;
            err_cnt    <= (se_n && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
        end
    end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: randomized and directed self-checking bench for tdm_demux4
module tb_tdm_demux4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] d_in = '0;
    logic       d_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] y0, y1, y2, y3;
    logic [1:0] s;
    logic [3:0] ch_valid;
    logic       frame_done, sync_err;
    logic [1:0] err_cnt;
    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.WIDTH(8), .ERRW(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in), .d_valid(d_valid), .sof(sof),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .s(s), .ch_valid(ch_valid),
        .frame_done(frame_done), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    wire [41:0] dut_v = {y0, y1, y2, y3, s, ch_valid, frame_done, sync_err, err_cnt};

    // reference model: pos is the next expected frame position, -1 while hunting
    int         pos = -1;
    logic [7:0] my [4];
    logic [1:0] ms;
    logic [3:0] mch;
    logic       mfd, mse;
    int         merr;

    function automatic logic [41:0] mdl_v();
        return {my[0], my[1], my[2], my[3], ms, mch, mfd, mse, 2'(merr)};
    endfunction

    task automatic model_reset();
        pos = -1;
        for (int i = 0; i < 4; i++) my[i] = '0;
        ms = '0; mch = '0; mfd = 0; mse = 0; merr = 0;
    endtask

    // drive one cycle, advance the model across the edge, sample 1ns later
    task automatic cyc(input logic e, input logic v, input logic sf, input logic [7:0] d);
        int k;
        en = e; d_valid = v; sof = sf; d_in = d;
        @(posedge clk);
        mch = '0; mfd = 0; mse = 0; k = -1;
        if (!e) begin
            pos = -1; ms = '0;
            for (int i = 0; i < 4; i++) my[i] = '0;
        end else if (v) begin
            if (pos < 0) k = sf ? 0 : -1;
            else if (sf) begin mse = pos != 0; k = 0; end
            else if (pos == 0) begin mse = 1; pos = -1; end
            else k = pos;
            if (k >= 0) begin
                my[k] = d; ms = 2'(k); mch = 4'(1 << k); mfd = k == 3; pos = (k + 1) % 4;
            end
            if (mse) merr = (merr < 3) ? merr + 1 : 3;
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_v !== 42'd0) begin errors++; $display("FAIL reset got %h exp 0", dut_v); end
        rst_n = 1'b1;
        cyc(1, 0, 0, 0);
        checks++;
        if (dut_v !== mdl_v()) begin errors++; $display("FAIL reset_idle got %h exp %h", dut_v, mdl_v()); end
    endtask

    task automatic test_frame();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, i == 0, d[i]);
            checks++;
            if (dut_v !== mdl_v()) begin errors++; $display("FAIL frame[%0d] got %h exp %h", i, dut_v, mdl_v()); end
            checks++;
            if ({ch_valid, s, frame_done} !== {4'(1 << i), 2'(i), i == 3}) begin
                errors++; $display("FAIL frame_strobe[%0d] got %b exp %b", i, {ch_valid, s, frame_done}, {4'(1 << i), 2'(i), i == 3});
            end
        end
        checks++;
        if ({y0, y1, y2, y3} !== 32'h11223344) begin errors++; $display("FAIL frame_y got %h exp 11223344", {y0, y1, y2, y3}); end
        cyc(1, 0, 0, 0);
        checks++;
        if ({ch_valid, frame_done, sync_err} !== 6'd0) begin errors++; $display("FAIL frame_pulse_clear got %b exp 0", {ch_valid, frame_done, sync_err}); end
    endtask

    task automatic test_gap();
        logic [7:0] d [6] = '{8'h55, 8'h66, 8'h00, 8'h00, 8'h77, 8'h88};
        for (int i = 0; i < 6; i++) begin
            cyc(1, !(i == 2 || i == 3), i == 0, d[i]);
            checks++;
            if (dut_v !== mdl_v()) begin errors++; $display("FAIL gap[%0d] got %h exp %h", i, dut_v, mdl_v()); end
            checks++;
            if (sync_err !== 1'b0) begin errors++; $display("FAIL gap_sync_err[%0d] got %b exp 0", i, sync_err); end
        end
        checks++;
        if ({y0, y1, y2, y3, frame_done} !== {32'h55667788, 1'b1}) begin errors++; $display("FAIL gap_y got %h exp 556677881", {y0, y1, y2, y3, frame_done}); end
    endtask

    task automatic test_hunt_drop();
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 8'hF0 + 8'(i));
            checks++;
            if ({y0, y1, y2, y3, ch_valid, sync_err} !== 37'd0) begin errors++; $display("FAIL hunt_drop[%0d] got %h exp 0", i, {y0, y1, y2, y3, ch_valid, sync_err}); end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, i == 0, 8'hA1 + 8'(i));
            checks++;
            if (dut_v !== mdl_v()) begin errors++; $display("FAIL hunt_frame[%0d] got %h exp %h", i, dut_v, mdl_v()); end
        end
        checks++;
        if ({y0, y1, y2, y3, err_cnt} !== {32'hA1A2A3A4, 2'd0}) begin errors++; $display("FAIL hunt_final got %h exp a1a2a3a40", {y0, y1, y2, y3, err_cnt}); end
    endtask

    task automatic test_early_sof();
        cyc(1, 1, 1, 8'h11);
        cyc(1, 1, 0, 8'h22);
        cyc(1, 1, 1, 8'hEE);
        checks++;
        if (dut_v !== mdl_v()) begin errors++; $display("FAIL early_sof got %h exp %h", dut_v, mdl_v()); end
        checks++;
        if ({sync_err, y0, ch_valid, err_cnt, y2, y3} !== {1'b1, 8'hEE, 4'b0001, 2'd1, 8'hA3, 8'hA4}) begin
            errors++; $display("FAIL early_sof_const got %h exp %h", {sync_err, y0, ch_valid, err_cnt, y2, y3}, {1'b1, 8'hEE, 4'b0001, 2'd1, 8'hA3, 8'hA4});
        end
    endtask

    task automatic test_missing_sof();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 8'h22 + 8'(i) * 8'h11);
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL missing_frame_done got %b exp 1", frame_done); end
        cyc(1, 1, 0, 8'h99);
        checks++;
        if ({sync_err, err_cnt, y0, ch_valid} !== {1'b1, 2'd2, 8'hEE, 4'd0}) begin errors++; $display("FAIL missing_sof got %h exp %h", {sync_err, err_cnt, y0, ch_valid}, {1'b1, 2'd2, 8'hEE, 4'd0}); end
        cyc(1, 1, 0, 8'h98);
        checks++;
        if (dut_v !== mdl_v() || sync_err !== 1'b0 || err_cnt !== 2'd2) begin errors++; $display("FAIL missing_hunt got %h exp %h", dut_v, mdl_v()); end
    endtask

    task automatic test_en_drop();
        cyc(1, 1, 1, 8'h10);
        cyc(1, 1, 0, 8'h20);
        cyc(0, 1, 0, 8'h30);
        checks++;
        if ({y0, y1, y2, y3, s, ch_valid, err_cnt} !== {32'd0, 2'd0, 4'd0, 2'd2}) begin errors++; $display("FAIL en_drop got %h exp %h", {y0, y1, y2, y3, s, ch_valid, err_cnt}, {32'd0, 2'd0, 4'd0, 2'd2}); end
        cyc(1, 1, 0, 8'h40);
        checks++;
        if (dut_v !== mdl_v() || {y0, sync_err} !== 9'd0) begin errors++; $display("FAIL en_drop_hunt got %h exp %h", dut_v, mdl_v()); end
    endtask

    task automatic test_async_reset();
        cyc(1, 1, 1, 8'h01);
        cyc(1, 1, 0, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_v !== 42'd0) begin errors++; $display("FAIL async_reset got %h exp 0", dut_v); end
        model_reset();
        #1 rst_n = 1'b1;
        cyc(1, 1, 0, 8'h03);
        checks++;
        if (dut_v !== mdl_v()) begin errors++; $display("FAIL async_after got %h exp %h", dut_v, mdl_v()); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 1, 8'(i));
            checks++;
            if (dut_v !== mdl_v()) begin errors++; $display("FAIL sat[%0d] got %h exp %h", i, dut_v, mdl_v()); end
        end
        checks++;
        if ({err_cnt, sync_err} !== {2'd3, 1'b1}) begin errors++; $display("FAIL sat_final got %b exp 111", {err_cnt, sync_err}); end
    endtask

    task automatic test_random();
        logic e, v, sf;
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom % 20) != 0;
            v  = ($urandom % 4) != 0;
            sf = (pos <= 0) ? (($urandom % 6) != 0) : (($urandom % 12) == 0);
            cyc(e, v, sf, 8'($urandom));
            checks++;
            if (dut_v !== mdl_v()) begin errors++; $display("FAIL random[%0d] got %h exp %h", i, dut_v, mdl_v()); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gap();
        test_hunt_drop();
        test_early_sof();
        test_missing_sof();
        test_en_drop();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
